// File: rtl/freelist_ctrl_pkg.sv
// Shared rename definitions: machine widths, free-list pointer types and index helper.
package freelist_ctrl_pkg;

  localparam int unsigned WAY          = 3;
  localparam int unsigned PHY_REG_NUM  = 64;
  localparam int unsigned ARCH_REG_NUM = 32;

  localparam int unsigned FL_DEPTH     = PHY_REG_NUM - ARCH_REG_NUM;
  localparam int unsigned FL_IDX_LEN   = $clog2(FL_DEPTH);
  // One extra MSB acts as the wrap bit so full and empty are distinguishable.
  localparam int unsigned FL_PTR_LEN   = FL_IDX_LEN + 1;
  localparam int unsigned WAY_CNT_LEN  = $clog2(WAY + 1);
  localparam int unsigned PHY_IDX_LEN  = $clog2(PHY_REG_NUM);
  localparam int unsigned ARCH_IDX_LEN = $clog2(ARCH_REG_NUM);

  typedef logic [PHY_IDX_LEN-1:0]  phy_reg_idx_t;
  typedef logic [ARCH_IDX_LEN-1:0] arch_reg_idx_t;
  typedef logic [FL_PTR_LEN-1:0]   fl_ptr_t;
  typedef logic [FL_IDX_LEN-1:0]   fl_idx_t;
  typedef logic [WAY_CNT_LEN-1:0]  way_cnt_t;

  // Storage index of a wrap-bit pointer.
  function automatic fl_idx_t fl_idx(input fl_ptr_t ptr);
    return ptr[FL_IDX_LEN-1:0];
  endfunction

endpackage

// File: rtl/way_prefix_cnt.sv
// Per-slot exclusive prefix popcount of a WAY-wide mask, plus the total popcount.
module way_prefix_cnt
  import freelist_ctrl_pkg::*;
(
  input  logic     [WAY-1:0] mask_i,
  output way_cnt_t [WAY-1:0] prefix_o,
  output way_cnt_t           total_o
);

  way_cnt_t acc;

  // Ripple accumulate: slot i sees the count of set bits strictly below it.
  always_comb begin
    acc      = '0;
    prefix_o = '0;
    for (int i = 0; i < WAY; i++) begin
      prefix_o[i] = acc;
      acc         = acc + way_cnt_t'(mask_i[i]);
    end
    total_o = acc;
  end

endmodule

// File: rtl/freelist_ctrl.sv
// Physical-register free list: compacted grants to dispatch, reclaim at retire,
// speculative head restored to the architectural head on squash.
module freelist_ctrl
  import freelist_ctrl_pkg::*;
(
  input  logic                          clock,
  input  logic                          reset_n,
  // Dispatch side
  input  way_cnt_t                      num_to_dispatch,
  input  arch_reg_idx_t [WAY-1:0]       arch_dest_reg,
  output phy_reg_idx_t  [WAY-1:0]       dispatch_free_reg,
  output way_cnt_t                      free_reg_valid,
  // Retire side
  input  way_cnt_t                      retire_num,
  input  logic          [WAY-1:0]       retire_has_dest,
  input  phy_reg_idx_t  [WAY-1:0]       retire_old_reg,
  input  logic                          squash,
  output fl_ptr_t                       free_count
);

  // Pointer state: head is speculative, arch_head tracks committed allocations.
  fl_ptr_t      head_q, head_d;
  fl_ptr_t      arch_head_q, arch_head_d;
  fl_ptr_t      tail_q, tail_d;
  phy_reg_idx_t fl_mem_q [FL_DEPTH];
  phy_reg_idx_t fl_mem_d [FL_DEPTH];

  logic     [WAY-1:0] alloc_mask;
  logic     [WAY-1:0] free_mask;
  way_cnt_t [WAY-1:0] alloc_pre;
  way_cnt_t [WAY-1:0] free_pre;
  way_cnt_t           alloc_total;
  way_cnt_t           free_total;
  way_cnt_t           alloc_eff;
  fl_ptr_t            count;
  fl_ptr_t  [WAY-1:0] rd_ptr;

  // Slot masks for allocation and reclaim.
  always_comb begin
    alloc_mask = '0;
    free_mask  = '0;
    for (int i = 0; i < WAY; i++) begin
      alloc_mask[i] = (way_cnt_t'(i) < num_to_dispatch) && (arch_dest_reg[i] != '0);
      free_mask[i]  = (way_cnt_t'(i) < retire_num) && retire_has_dest[i];
    end
  end

  way_prefix_cnt u_alloc_cnt (
    .mask_i   (alloc_mask),
    .prefix_o (alloc_pre),
    .total_o  (alloc_total)
  );

  way_prefix_cnt u_free_cnt (
    .mask_i   (free_mask),
    .prefix_o (free_pre),
    .total_o  (free_total)
  );

  // Occupancy and valid count depend on registered state only.
  always_comb begin
    count      = tail_q - head_q;
    free_count = count;
    if (count >= fl_ptr_t'(WAY)) begin
      free_reg_valid = way_cnt_t'(WAY);
    end else begin
      free_reg_valid = way_cnt_t'(count);
    end
  end

  // Grants: allocating slots read compacted entries; idle slots show head+i.
  always_comb begin
    rd_ptr            = '0;
    dispatch_free_reg = '0;
    for (int i = 0; i < WAY; i++) begin
      if (alloc_mask[i]) begin
        rd_ptr[i] = head_q + fl_ptr_t'(alloc_pre[i]);
      end else begin
        rd_ptr[i] = head_q + fl_ptr_t'(i);
      end
      dispatch_free_reg[i] = fl_mem_q[fl_idx(rd_ptr[i])];
    end
  end

  // Pointer next state; squash drops this cycle's dispatch and rewinds to the
  // committed head, which already includes same-cycle commits.
  always_comb begin
    alloc_eff   = squash ? '0 : alloc_total;
    arch_head_d = arch_head_q + fl_ptr_t'(free_total);
    tail_d      = tail_q + fl_ptr_t'(free_total);
    if (squash) begin
      head_d = arch_head_d;
    end else begin
      head_d = head_q + fl_ptr_t'(alloc_eff);
    end
  end

  // Reclaimed registers are packed in slot order starting at tail.
  always_comb begin
    fl_mem_d = fl_mem_q;
    for (int i = 0; i < WAY; i++) begin
      if (free_mask[i]) begin
        fl_mem_d[fl_idx(tail_q + fl_ptr_t'(free_pre[i]))] = retire_old_reg[i];
      end
    end
  end

  // Pointer registers; tail starts one full lap ahead of head.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      head_q      <= '0;
      arch_head_q <= '0;
      tail_q      <= fl_ptr_t'(FL_DEPTH);
    end else begin
      head_q      <= head_d;
      arch_head_q <= arch_head_d;
      tail_q      <= tail_d;
    end
  end

  // Free-list storage; initially holds every non-architectural register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < FL_DEPTH; i++) begin
        fl_mem_q[i] <= phy_reg_idx_t'(ARCH_REG_NUM + i);
      end
    end else begin
      fl_mem_q <= fl_mem_d;
    end
  end

  // Illegal-input checks; the design does not attempt to recover.
  always_ff @(posedge clock) begin
    if (reset_n) begin
      assert (squash || (alloc_total <= free_reg_valid));
      assert (({1'b0, count} + (FL_PTR_LEN+1)'(free_total)) <= (FL_PTR_LEN+1)'(FL_DEPTH));
      assert (retire_num <= way_cnt_t'(WAY));
    end
  end

endmodule

// File: tb/tb_freelist_ctrl.sv
// Directed and randomized checks of freelist_ctrl against a queue-based reference.
module tb_freelist_ctrl;
  import freelist_ctrl_pkg::*;

  logic                    clock = 1'b0;
  logic                    reset_n = 1'b1;
  way_cnt_t                num_to_dispatch;
  arch_reg_idx_t [WAY-1:0] arch_dest_reg;
  phy_reg_idx_t  [WAY-1:0] dispatch_free_reg;
  way_cnt_t                free_reg_valid;
  way_cnt_t                retire_num;
  logic          [WAY-1:0] retire_has_dest;
  phy_reg_idx_t  [WAY-1:0] retire_old_reg;
  logic                    squash;
  fl_ptr_t                 free_count;

  int tests = 0;
  int fails = 0;

  // Reference: queue of everything from the committed head to the tail, and
  // the number of its leading entries handed out speculatively.
  int free_q[$];
  int spec;

  freelist_ctrl dut (
    .clock             (clock),
    .reset_n           (reset_n),
    .num_to_dispatch   (num_to_dispatch),
    .arch_dest_reg     (arch_dest_reg),
    .dispatch_free_reg (dispatch_free_reg),
    .free_reg_valid    (free_reg_valid),
    .retire_num        (retire_num),
    .retire_has_dest   (retire_has_dest),
    .retire_old_reg    (retire_old_reg),
    .squash            (squash),
    .free_count        (free_count)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    free_q.delete();
    for (int i = 0; i < int'(FL_DEPTH); i++) free_q.push_back(int'(ARCH_REG_NUM) + i);
    spec = 0;
  endtask

  task automatic set_disp(input int n, input int a0, input int a1, input int a2);
    num_to_dispatch  = way_cnt_t'(n);
    arch_dest_reg[0] = arch_reg_idx_t'(a0);
    arch_dest_reg[1] = arch_reg_idx_t'(a1);
    arch_dest_reg[2] = arch_reg_idx_t'(a2);
  endtask

  task automatic set_ret(input int n, input logic [2:0] has, input int o0, input int o1,
                         input int o2);
    retire_num        = way_cnt_t'(n);
    retire_has_dest   = has;
    retire_old_reg[0] = phy_reg_idx_t'(o0);
    retire_old_reg[1] = phy_reg_idx_t'(o1);
    retire_old_reg[2] = phy_reg_idx_t'(o2);
  endtask

  task automatic idle();
    set_disp(0, 0, 0, 0);
    set_ret(0, 3'b000, 0, 0, 0);
    squash = 1'b0;
  endtask

  // Called after inputs settle: compare against the model, advance both one cycle.
  task automatic cycle_check();
    int avail;
    int pre;
    int fr[$];
    avail = free_q.size() - spec;
    check("free_count", free_count, avail);
    check("free_reg_valid", free_reg_valid, (avail < int'(WAY)) ? avail : int'(WAY));
    pre = 0;
    for (int i = 0; i < int'(WAY); i++) begin
      if (i < int'(num_to_dispatch) && arch_dest_reg[i] != 0) begin
        check($sformatf("grant%0d", i), dispatch_free_reg[i], free_q[spec + pre]);
        pre++;
      end
    end
    for (int i = 0; i < int'(WAY); i++)
      if (i < int'(retire_num) && retire_has_dest[i]) fr.push_back(int'(retire_old_reg[i]));
    if (!squash) spec += pre;
    foreach (fr[k]) begin
      void'(free_q.pop_front());
      free_q.push_back(fr[k]);
      spec--;
    end
    if (squash) spec = 0;
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic do_reset(input string tag);
    idle();
    reset_n = 1'b0;
    #1;
    check({tag, "_count"}, free_count, 32);
    check({tag, "_valid"}, free_reg_valid, 3);
    check({tag, "_g0"}, dispatch_free_reg[0], 32);
    check({tag, "_g1"}, dispatch_free_reg[1], 33);
    check({tag, "_g2"}, dispatch_free_reg[2], 34);
    @(negedge clock);
    reset_n = 1'b1;
    model_reset();
  endtask

  initial begin
    idle();
    #1;
    do_reset("reset");

    // Squash: 5 allocs, 2 commits freeing {1,2}, then squash.
    set_disp(3, 1, 2, 3); #1; cycle_check();
    set_disp(2, 4, 5, 0); #1; cycle_check();
    idle(); set_ret(2, 3'b011, 1, 2, 0); #1; cycle_check();
    idle(); #1;
    check("sq_pre_count", free_count, 29);
    squash = 1'b1; cycle_check();
    idle(); set_disp(1, 6, 0, 0); #1;
    check("sq_count", free_count, 32);
    check("sq_grant", dispatch_free_reg[0], 34);
    cycle_check();

    // Squash with same-cycle dispatch and retire.
    set_disp(3, 1, 2, 3); set_ret(1, 3'b001, 7, 0, 0); squash = 1'b1; #1; cycle_check();
    idle(); set_disp(1, 9, 0, 0); #1;
    check("sqd_count", free_count, 32);
    check("sqd_grant", dispatch_free_reg[0], 35);
    cycle_check();

    // Compaction from reset.
    do_reset("reset2");
    set_disp(3, 5, 0, 7); #1;
    check("cmp_slot0", dispatch_free_reg[0], 32);
    check("cmp_slot2", dispatch_free_reg[2], 33);
    cycle_check();
    idle(); #1;
    check("cmp_count", free_count, 30);
    check("cmp_next", dispatch_free_reg[0], 34);

    // Drain to empty, then free two registers.
    for (int c = 0; c < 10; c++) begin
      set_disp(3, 1, 2, 3); #1; cycle_check();
    end
    idle(); set_ret(2, 3'b011, 3, 9, 0); #1;
    check("empty_valid", free_reg_valid, 0);
    cycle_check();
    idle(); set_disp(2, 4, 5, 0); #1;
    check("refill_valid", free_reg_valid, 2);
    check("refill_g0", dispatch_free_reg[0], 3);
    check("refill_g1", dispatch_free_reg[1], 9);
    cycle_check();

    // Randomized traffic against the reference.
    for (int c = 0; c < 400; c++) begin
      int avail;
      int room;
      int k;
      int nf;
      avail = free_q.size() - spec;
      room  = (avail < int'(WAY)) ? avail : int'(WAY);
      num_to_dispatch = way_cnt_t'($urandom_range(0, WAY));
      k = 0;
      for (int i = 0; i < int'(WAY); i++) begin
        arch_dest_reg[i] = ($urandom_range(0, 3) == 0) ? '0 : arch_reg_idx_t'($urandom_range(1, 31));
        if (i < int'(num_to_dispatch) && arch_dest_reg[i] != 0) begin
          if (k < room) k++;
          else arch_dest_reg[i] = '0;
        end
      end
      retire_num = way_cnt_t'($urandom_range(0, WAY));
      nf = 0;
      for (int i = 0; i < int'(WAY); i++) begin
        retire_has_dest[i] = 1'($urandom_range(0, 1));
        retire_old_reg[i]  = phy_reg_idx_t'($urandom_range(1, 63));
        if (i < int'(retire_num) && retire_has_dest[i]) begin
          if (nf < spec) nf++;
          else retire_has_dest[i] = 1'b0;
        end
      end
      squash = ($urandom_range(0, 15) == 0);
      #1;
      cycle_check();
    end

    // Commit everything outstanding, then leave 7 free and reset mid-operation.
    idle();
    while (spec > 0) begin
      int n;
      n = (spec < int'(WAY)) ? spec : int'(WAY);
      set_ret(n, 3'b111, $urandom_range(1, 63), $urandom_range(1, 63), $urandom_range(1, 63));
      #1; cycle_check();
    end
    idle();
    for (int c = 0; c < 9; c++) begin
      if (c < 8) set_disp(3, 1, 2, 3);
      else set_disp(1, 1, 0, 0);
      #1; cycle_check();
    end
    idle(); #1;
    check("mid_count", free_count, 7);
    do_reset("midreset");
    idle(); #1; cycle_check();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
